// File: rtl/trng_collector.sv
// Multi-channel entropy collector: XOR-folds synchronised noise into 32-bit words,
// buffers them in a FIFO and runs a repetition-count health test.
// Optional macro TRNG_COLLECTOR_RAW_EN adds the RAW characterisation register and CTRL bit3 bypass.
module trng_collector #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned RCT_CUTOFF   = 32,
  parameter logic [23:0] DEFAULT_RATE = 24'h001000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs,
  input  logic              we,
  input  logic [7:0]        address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  input  logic [NUM_CH-1:0] noise,
  output logic              health_error
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam logic [7:0]  CUTOFF = 8'(RCT_CUTOFF);

  localparam logic [7:0] ADDR_NAME0   = 8'h00;
  localparam logic [7:0] ADDR_NAME1   = 8'h01;
  localparam logic [7:0] ADDR_VERSION = 8'h02;
  localparam logic [7:0] ADDR_STATUS  = 8'h09;
  localparam logic [7:0] ADDR_CTRL    = 8'h0a;
  localparam logic [7:0] ADDR_RATE    = 8'h10;
  localparam logic [7:0] ADDR_ENTROPY = 8'h20;
`ifdef TRNG_COLLECTOR_RAW_EN
  localparam logic [7:0] ADDR_RAW     = 8'h30;
`endif

  logic [NUM_CH-1:0] meta_q, sync_q;
  logic              enable_q, enable_d;
  logic [23:0]       rate_q, rate_d;
  logic [23:0]       cnt_q, cnt_d;
  logic [31:0]       coll_q, coll_d;
  logic [5:0]        bits_q, bits_d;
  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              health_error_q, health_error_d;
  logic [7:0]        run_q, run_d;
  logic              prev_q, prev_d;
`ifdef TRNG_COLLECTOR_RAW_EN
  logic              bypass_q, bypass_d;
`endif

  logic        fifo_empty_c, fifo_full_c;
  logic        ctrl_wr_c, rate_wr_c, pop_c, push_c, flush_c;
  logic        active_c, strobe_c, fold_c;
  logic [23:0] rate_m1_c;
  logic [7:0]  run_next_c;
  logic        unused_ok_c;

  assign ready        = cs;
  assign health_error = health_error_q;
  assign unused_ok_c  = ^write_data[31:24];

  assign fifo_empty_c = (count_q == '0);
  assign fifo_full_c  = (count_q == CNT_W'(DEPTH));
  assign ctrl_wr_c    = cs & we & (address == ADDR_CTRL);
  assign rate_wr_c    = cs & we & (address == ADDR_RATE);
  assign flush_c      = ctrl_wr_c & write_data[2];
  assign pop_c        = cs & ~we & (address == ADDR_ENTROPY) & ~fifo_empty_c;

  // A full collector word stalls sampling until it has been pushed.
  assign active_c  = enable_q & ~health_error_q & (bits_q != 6'd32);
  assign rate_m1_c = (rate_q == 24'd0) ? 24'd0 : rate_q - 24'd1;
  assign strobe_c  = active_c & (cnt_q >= rate_m1_c);
  assign push_c    = enable_q & ~health_error_q & (bits_q == 6'd32)
                   & (~fifo_full_c | pop_c) & ~flush_c;

  always_comb begin
    fold_c = ^sync_q;
`ifdef TRNG_COLLECTOR_RAW_EN
    if (bypass_q) fold_c = sync_q[0];
`endif
  end

  assign run_next_c = (fold_c == prev_q) ? run_q + 8'd1 : 8'd1;

  // Next-state for sampling, collector, FIFO and health test; register writes override last.
  always_comb begin
    enable_d       = enable_q;
    rate_d         = rate_q;
    cnt_d          = cnt_q;
    coll_d         = coll_q;
    bits_d         = bits_q;
    mem_d          = mem_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    health_error_d = health_error_q;
    run_d          = run_q;
    prev_d         = prev_q;
`ifdef TRNG_COLLECTOR_RAW_EN
    bypass_d       = bypass_q;
`endif

    if (strobe_c) begin
      cnt_d  = 24'd0;
      coll_d = {coll_q[30:0], fold_c};
      bits_d = bits_q + 6'd1;
      prev_d = fold_c;
      run_d  = run_next_c;
      if (run_next_c >= CUTOFF) health_error_d = 1'b1;
    end else if (active_c) begin
      cnt_d = cnt_q + 24'd1;
    end

    if (push_c) begin
      mem_d[wr_ptr_q] = coll_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      bits_d          = 6'd0;
      coll_d          = 32'd0;
    end
    if (pop_c && !flush_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (push_c && !(pop_c && !flush_c))      count_d = count_q + CNT_W'(1);
    else if (!push_c && pop_c && !flush_c)   count_d = count_q - CNT_W'(1);

    if (ctrl_wr_c) begin
      enable_d = write_data[0];
`ifdef TRNG_COLLECTOR_RAW_EN
      bypass_d = write_data[3];
`endif
      if (write_data[1]) begin
        health_error_d = 1'b0;
        run_d          = 8'd0;
        bits_d         = 6'd0;
        coll_d         = 32'd0;
      end
      if (write_data[2]) begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        count_d  = '0;
        bits_d   = 6'd0;
        coll_d   = 32'd0;
      end
    end

    if (rate_wr_c) begin
      rate_d = write_data[23:0];
      cnt_d  = 24'd0;
      bits_d = 6'd0;
      coll_d = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q         <= '0;
      sync_q         <= '0;
      enable_q       <= 1'b1;
      rate_q         <= DEFAULT_RATE;
      cnt_q          <= 24'd0;
      coll_q         <= 32'd0;
      bits_q         <= 6'd0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      health_error_q <= 1'b0;
      run_q          <= 8'd0;
      prev_q         <= 1'b0;
`ifdef TRNG_COLLECTOR_RAW_EN
      bypass_q       <= 1'b0;
`endif
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 32'd0;
    end else begin
      meta_q         <= noise;
      sync_q         <= meta_q;
      enable_q       <= enable_d;
      rate_q         <= rate_d;
      cnt_q          <= cnt_d;
      coll_q         <= coll_d;
      bits_q         <= bits_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      health_error_q <= health_error_d;
      run_q          <= run_d;
      prev_q         <= prev_d;
`ifdef TRNG_COLLECTOR_RAW_EN
      bypass_q       <= bypass_d;
`endif
      mem_q          <= mem_d;
    end
  end

  // Combinational register read mux.
  always_comb begin
    read_data = 32'd0;
    if (cs) begin
      case (address)
        ADDR_NAME0:   read_data = 32'h74726e67;
        ADDR_NAME1:   read_data = 32'h636f6c20;
        ADDR_VERSION: read_data = 32'h00000002;
        ADDR_STATUS:  read_data = {19'd0, 5'(count_q), 5'd0, fifo_full_c, health_error_q, ~fifo_empty_c};
        ADDR_CTRL:    read_data = {31'd0, enable_q};
        ADDR_RATE:    read_data = {8'd0, rate_q};
        ADDR_ENTROPY: read_data = fifo_empty_c ? 32'd0 : mem_q[rd_ptr_q];
`ifdef TRNG_COLLECTOR_RAW_EN
        ADDR_RAW:     read_data = {run_q, 16'd0, 8'(sync_q)};
`endif
        default:      read_data = 32'd0;
      endcase
    end
  end

endmodule
